spi3w_responder: RTL
====================

SPI3W_RESPONDER -- requirements
Module: spi3w_responder

Interface
REQ-001 Parameter ADDR_W, default 7: register address width; frame length is 1+ADDR_W+DATA_W bits.
REQ-002 Parameter DATA_W, default 8: register data width.
REQ-003 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-high.
REQ-005 sclk_in  input  1  SPI clock from initiator, asynchronous to clk, mode 0 (idle low).
REQ-006 ss_in  input  1  slave select, active-low, asynchronous.
REQ-007 sdio_i  input  1  shared data line, input side of the top-level tristate.
REQ-008 sdio_o  output  1  shared data line, output value.
REQ-009 sdio_oe  output  1  tristate enable; 1 = this block drives sdio.
REQ-010 reg_addr  output  ADDR_W  register address, held stable from decode to the end of the frame.
REQ-011 reg_wdata  output  DATA_W  write data, valid while reg_we=1.
REQ-012 reg_we  output  1  one-clk write strobe.
REQ-013 reg_re  output  1  one-clk read strobe.
REQ-014 reg_rdata  input  DATA_W  read data; valid the clk after reg_re.
REQ-015 frame_err  output  1  one-clk pulse on an aborted frame.

Function
REQ-016 sclk_in, ss_in and sdio_i SHALL each pass through a 2-flop synchronizer; a third flop on sclk and ss SHALL provide edge detection, so a pin edge is acted on 3 clk later.
REQ-017 Frame format, MSB first: bit 0 = R/W (1 = read), then ADDR_W address bits, then DATA_W data bits.
REQ-018 The block SHALL sample sdio on detected sclk rising edges and update sdio_o on detected sclk falling edges.
REQ-019 State machine: IDLE, CMD, WDATA, RDATA, DONE.
REQ-020 IDLE -> CMD on detected ss falling edge; bit counter cleared.
REQ-021 CMD: shift in 1+ADDR_W bits; after the last one, latch reg_addr, then go to WDATA (R/W=0) or RDATA (R/W=1) with reg_re pulsed on the same clk.
REQ-022 RDATA: capture reg_rdata into the shift register 2 clk after reg_re; on each subsequent detected sclk falling edge drive the next bit, MSB first, with sdio_oe=1 from the first falling edge.
REQ-023 WDATA: shift in DATA_W bits; after the last one, pulse reg_we for one clk with reg_wdata = the received byte; go to DONE.
REQ-024 RDATA -> DONE after the DATA_W-th rising edge; sdio_oe SHALL drop on the next detected falling edge or on ss rise, whichever is first.
REQ-025 DONE: ignore further sclk edges; -> IDLE on detected ss rising edge.
REQ-026 A detected ss rising edge in CMD, WDATA or RDATA before frame completion SHALL abort: -> IDLE, sdio_oe=0, no reg_we, frame_err pulsed one clk.
REQ-027 sdio_oe SHALL never be 1 in IDLE, CMD, WDATA or DONE.
REQ-028 Supported timing: sclk high and low phases each >= 4 clk periods, ss setup/hold >= 4 clk; behaviour outside this is undefined.
REQ-029 An ss falling edge while not in IDLE SHALL be ignored.

Reset
REQ-030 During rst: state=IDLE, counters and shift registers 0, sdio_oe=0, sdio_o=0, reg_we=0, reg_re=0, frame_err=0, reg_addr=0, reg_wdata=0; synchronizers reset to sclk=0, ss=1.
REQ-031 rst asserted mid-frame SHALL release sdio_oe immediately (asynchronously); after release the block waits in IDLE for a new ss falling edge.

Verification
REQ-032 Write frame 0_0000101_10100101 (sclk 8 clk period) -> single reg_we with reg_addr=0x05, reg_wdata=0xA5; sdio_oe stays 0.
REQ-033 Read frame 1_0010011 with reg_rdata=0x3C -> reg_re once, reg_addr=0x13; initiator samples 0,0,1,1,1,1,0,0; sdio_oe high only during the data phase.
REQ-034 ss raised after 5 command bits -> frame_err pulse, no reg_we/reg_re, state IDLE; the next valid write completes normally.
REQ-035 Write frame followed by 4 extra sclk pulses before ss rises -> exactly one reg_we, data unchanged.
REQ-036 rst asserted during the read data phase -> sdio_oe=0 within the same cycle, no frame_err; a following read returns correct data.
REQ-037 Back-to-back frames with minimum ss high time of 4 clk -> both frames decoded correctly.

Source files
------------

// File: rtl/spi3w_responder_if.sv
// SPI 3-wire responder bus bundle.
// Pin side plus register-access side.
interface spi3w_responder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              sclk_in;
  logic              ss_in;
  logic              sdio_i;
  logic              sdio_o;
  logic              sdio_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              frame_err;

  modport slave (
    input  sclk_in, ss_in, sdio_i, reg_rdata,
    output sdio_o, sdio_oe, reg_addr,
    output reg_wdata, reg_we, reg_re, frame_err
  );

  modport master (
    output sclk_in, ss_in, sdio_i, reg_rdata,
    input  sdio_o, sdio_oe, reg_addr,
    input  reg_wdata, reg_we, reg_re, frame_err
  );
endinterface

// File: rtl/spi3w_responder.sv
// SPI mode-0 3-wire register responder.
// Oversamples sclk/ss/sdio in the clk domain.
module spi3w_responder #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  spi3w_responder_if.slave bus
);
  localparam int CW = $clog2(ADDR_W + DATA_W + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE
  } state_t;

  logic [2:0] r_sclk_s;
  logic [2:0] r_ss_s;
  logic [1:0] r_sdio_s;

  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_cmd, w_cmd;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic              r_we, w_we;
  logic              r_re, w_re;
  logic              r_ferr, w_ferr;
  logic              r_oe, w_oe;
  logic              r_o, w_o;
  logic              r_cap, w_cap;

  logic              w_sclk_rise, w_sclk_fall;
  logic              w_ss_rise, w_ss_fall;
  logic              w_bit;
  logic [ADDR_W:0]   w_cmd_nx;
  logic [DATA_W-1:0] w_shift_in;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_ss_rise   = r_ss_s[1] & ~r_ss_s[2];
  assign w_ss_fall   = ~r_ss_s[1] & r_ss_s[2];
  assign w_bit       = r_sdio_s[1];
  assign w_cmd_nx    = {r_cmd, w_bit};
  assign w_shift_in  = {r_shift[DATA_W-2:0], w_bit};

  // Two-flop synchronizers; third flop on sclk/ss for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_ss_s   <= '1;
      r_sdio_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], bus.sclk_in};
      r_ss_s   <= {r_ss_s[1:0], bus.ss_in};
      r_sdio_s <= {r_sdio_s[0], bus.sdio_i};
    end
  end

  // State and datapath registers; async reset drops sdio_oe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_shift <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_ferr  <= 1'b0;
      r_oe    <= 1'b0;
      r_o     <= 1'b0;
      r_cap   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_cmd   <= w_cmd;
      r_shift <= w_shift;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_we    <= w_we;
      r_re    <= w_re;
      r_ferr  <= w_ferr;
      r_oe    <= w_oe;
      r_o     <= w_o;
      r_cap   <= w_cap;
    end
  end

  // Frame sequencing: next state, strobes and shift control.
  // RDATA holds after the last bit until the next falling edge
  // so the initiator's final sample still sees a driven line.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_cmd   = r_cmd;
    w_shift = r_shift;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_ferr  = 1'b0;
    w_oe    = r_oe;
    w_o     = r_o;
    w_cap   = r_re;
    unique case (r_state)
      S_IDLE: begin
        w_oe = 1'b0;
        if (w_ss_fall) begin
          w_state = S_CMD;
          w_cnt   = '0;
          w_cmd   = '0;
        end
      end
      S_CMD: begin
        if (w_ss_rise) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_ferr  = 1'b1;
        end else if (w_sclk_rise) begin
          w_cmd = w_cmd_nx[ADDR_W-1:0];
          if (r_cnt == CW'(ADDR_W)) begin
            w_addr  = w_cmd_nx[ADDR_W-1:0];
            w_cnt   = '0;
            w_shift = '0;
            w_re    = w_cmd_nx[ADDR_W];
            w_state = w_cmd_nx[ADDR_W] ? S_RDATA : S_WDATA;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
      S_WDATA: begin
        if (w_ss_rise) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_ferr  = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift = w_shift_in;
          if (r_cnt == CW'(DATA_W - 1)) begin
            w_we    = 1'b1;
            w_wdata = w_shift_in;
            w_cnt   = '0;
            w_state = S_DONE;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
      S_RDATA: begin
        if (w_ss_rise) begin
          w_state = S_IDLE;
          w_oe    = 1'b0;
          w_o     = 1'b0;
          w_ferr  = (r_cnt != CW'(DATA_W));
          w_cnt   = '0;
        end else if (r_cap) begin
          w_shift = bus.reg_rdata;
        end else if (w_sclk_fall) begin
          if (r_cnt == CW'(DATA_W)) begin
            w_oe    = 1'b0;
            w_o     = 1'b0;
            w_cnt   = '0;
            w_state = S_DONE;
          end else begin
            w_oe    = 1'b1;
            w_o     = r_shift[DATA_W-1];
            w_shift = {r_shift[DATA_W-2:0], 1'b0};
          end
        end else if (w_sclk_rise && r_cnt != CW'(DATA_W)) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_oe = 1'b0;
        if (w_ss_rise) w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_oe    = 1'b0;
      end
    endcase
  end

  assign bus.sdio_o    = r_o;
  assign bus.sdio_oe   = r_oe;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_we    = r_we;
  assign bus.reg_re    = r_re;
  assign bus.frame_err = r_ferr;
endmodule
